uart_cmd_resolver_p: RTL and testbench
======================================

Name: uart_cmd_resolver_p

Overview:
Parametrised UART command receiver and frame decoder for the local-dimming control path.
- Deserialises 8N1 bytes from the host UART line.
- Parses frames of the form header, cmd code, length, N parameter bytes, check byte.
- Validates the frame and presents the decoded command as a one-cycle strobe with held payload.
- Successor to the fixed 4-byte decoder: adds a configurable parameter count, selectable checksum mode, error reporting and an inter-byte timeout.

Parameters:
CLK_FREQ_HZ, 50000000, system clock frequency in Hz
BAUD_RATE, 115200, UART bit rate; bit divisor BIT_DIV = CLK_FREQ_HZ/BAUD_RATE, truncated (434 at defaults)
MAX_PARA, 4, maximum parameter bytes per frame (1..16)
HEADER_BYTE, 8'hAA, frame start byte
CHK_MODE, 0, 0 = 8-bit sum mod 256, 1 = XOR; both computed over cmd, len and params
TIMEOUT_BITS, 32, idle bit-times allowed between bytes inside a frame before abort

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
uart_rx  in  1  asynchronous serial input, idle high
cmd_valid  out  1  one-cycle strobe: frame received with good check
cmd_code  out  8  command code of the last good frame
cmd_len  out  8  parameter count of the last good frame
para_list  out  8*MAX_PARA  params; byte 0 in [7:0], byte k in [8k+7:8k]; unused bytes zero
check_rx  out  8  check byte received in the last completed frame
chk_err  out  1  one-cycle strobe: check mismatch, frame dropped
frm_err  out  1  one-cycle strobe: stop bit low, length > MAX_PARA, or timeout; frame dropped
busy  out  1  high while the parser is not in S_HDR

Behaviour:
Reset:
- All outputs are 0.
- Parser is in S_HDR; RX core is idle.
- The synchroniser flops reset to 1.
- Reset taken mid-byte or mid-frame discards everything received so far.

RX core:
- uart_rx passes through a 2-flop synchroniser.
- A falling edge in idle starts a bit counter.
- Start bit is re-sampled at BIT_DIV/2. If it reads high, the core treats it as a glitch and returns to idle.
- Data bits are sampled at BIT_DIV intervals, LSB first.
- Stop bit is sampled at mid-bit. Byte strobe rx_vld pulses 1 cycle with rx_data, together with rx_ferr = !stop.
- After stop, the core re-arms immediately on the next falling edge. Back-to-back bytes are supported with zero idle time.

Parser FSM, advancing on rx_vld:
- S_HDR: rx_data == HEADER_BYTE goes to S_CMD. Any other byte is ignored with no error.
- S_CMD: latch code, initialise check accumulator with code, go to S_LEN.
- S_LEN: fold len into the accumulator.
  - len > MAX_PARA: frm_err, go to S_HDR.
  - len == 0: go to S_CHK.
  - Otherwise clear the param shadow, reset the byte index, go to S_PARA.
- S_PARA: write byte at index, fold into the accumulator, increment index. When index reaches len, go to S_CHK.
- S_CHK: on a match, copy shadow code/len/params into the outputs and pulse cmd_valid. On a mismatch, pulse chk_err and leave outputs unchanged. check_rx updates in both cases. Go to S_HDR.

Error and timeout handling:
- rx_ferr on any byte in S_CMD..S_CHK pulses frm_err and returns to S_HDR. The same in S_HDR is silently ignored.
- Timeout counter clears on each rx_vld and counts clocks while the FSM is outside S_HDR. At TIMEOUT_BITS*BIT_DIV it pulses frm_err and returns to S_HDR.

Timing and strobes:
- Latency: cmd_valid/chk_err assert on the cycle after the check byte's rx_vld.
- Output registers change only in that cycle.
- Strobes are mutually exclusive and never assert on consecutive cycles for one frame.
- A header byte arriving in S_CHK is treated as the check byte, not as a resync.

Arithmetic:
- Accumulator is 8-bit with wrap.
- Byte index width is clog2(MAX_PARA+1).
- Timeout counter is sized for TIMEOUT_BITS*BIT_DIV.

Decomposition:
- Package uart_cmd_pkg holds:
  - state encoding S_HDR/S_CMD/S_LEN/S_PARA/S_CHK
  - CHK_SUM/CHK_XOR constants
  - the default HEADER_BYTE
  - a check_fold function (mode, acc, byte)
- One sub-module, uart_rx_core (CLK_FREQ_HZ, BAUD_RATE): synchroniser, bit timing, deserialiser; outputs rx_vld, rx_data, rx_ferr.
- Parser, accumulator and timeout live in uart_cmd_resolver_p.

Test Plan:
1. Defaults; send AA 01 04 11 22 33 44 AF -> cmd_valid once; cmd_code=01, cmd_len=04, para_list=32'h44332211, check_rx=AF, no error strobes.
2. CHK_MODE=1; send AA 01 04 11 22 33 44 41 -> cmd_valid. Same frame with check 42 -> chk_err once; outputs keep the previous values; check_rx=42.
3. MAX_PARA=4; send AA 05 06 ... -> frm_err after the len byte. A following good frame AA 02 00 02 -> cmd_valid; cmd_len=0; para_list=0.
4. Send 55 13 AA 03 01 7E 82 back-to-back with no idle -> garbage bytes ignored; cmd_valid with cmd_code=03, para_list[7:0]=7E.
5. Send AA 01 02 10, then idle > 32 bit-times -> frm_err once, busy falls. Then a good frame decodes normally. Separately, drive the stop bit low on a param byte -> frm_err.
6. Assert rst for 1 cycle mid-param byte -> all outputs 0, busy=0. A full good frame sent afterwards decodes correctly. A 1-clock low glitch on an idle line produces no rx_vld.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// Shared types and helpers for the UART command resolver: parser/RX state
// encodings, check-mode selectors and the check accumulator fold.
package uart_cmd_pkg;

  typedef enum logic [2:0] {S_HDR, S_CMD, S_LEN, S_PARA, S_CHK} state_e;
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_e;

  localparam logic CHK_SUM = 1'b0;
  localparam logic CHK_XOR = 1'b1;

  localparam logic [7:0] DEF_HEADER_BYTE = 8'hAA;

  function automatic logic [7:0] check_fold(input logic mode, input logic [7:0] acc,
                                            input logic [7:0] b);
    return (mode == CHK_XOR) ? (acc ^ b) : (acc + b);
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: 2-flop synchroniser, falling-edge start detect with
// mid-bit start re-check, LSB-first deserialiser, one-cycle byte strobe.
module uart_rx_core
  import uart_cmd_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50000000,
  parameter int BAUD_RATE   = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx,
  output logic       rx_vld,
  output logic [7:0] rx_data,
  output logic       rx_ferr
);

  localparam int BIT_DIV = CLK_FREQ_HZ / BAUD_RATE;
  localparam int HALF    = BIT_DIV / 2;
  localparam int CW      = $clog2(BIT_DIV + 1);

  rx_state_e   state_q, state_d;
  logic        sync1_q, sync2_q, prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        rx_vld_q, rx_vld_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_ferr_q, rx_ferr_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    bit_d     = bit_q;
    shift_d   = shift_q;
    rx_vld_d  = 1'b0;
    rx_data_d = rx_data_q;
    rx_ferr_d = 1'b0;
    case (state_q)
      R_IDLE: begin
        cnt_d = '0;
        if (prev_q && !sync2_q) state_d = R_START;
      end
      R_START: begin
        // A start bit that is high again at mid-bit was a glitch.
        if (cnt_q == CW'(HALF - 1)) begin
          cnt_d = '0;
          bit_d = '0;
          state_d = sync2_q ? R_IDLE : R_DATA;
        end
      end
      R_DATA: begin
        if (cnt_q == CW'(BIT_DIV - 1)) begin
          cnt_d   = '0;
          shift_d = {sync2_q, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = R_STOP;
        end
      end
      R_STOP: begin
        if (cnt_q == CW'(BIT_DIV - 1)) begin
          cnt_d     = '0;
          rx_vld_d  = 1'b1;
          rx_data_d = shift_q;
          rx_ferr_d = !sync2_q;
          state_d   = R_IDLE;
        end
      end
      default: state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      prev_q    <= 1'b1;
      state_q   <= R_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      rx_vld_q  <= 1'b0;
      rx_data_q <= '0;
      rx_ferr_q <= 1'b0;
    end else begin
      sync1_q   <= uart_rx;
      sync2_q   <= sync1_q;
      prev_q    <= sync2_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      rx_vld_q  <= rx_vld_d;
      rx_data_q <= rx_data_d;
      rx_ferr_q <= rx_ferr_d;
    end
  end

  assign rx_vld  = rx_vld_q;
  assign rx_data = rx_data_q;
  assign rx_ferr = rx_ferr_q;

endmodule

// File: rtl/uart_cmd_resolver_p.sv
// UART command frame decoder: AA, cmd, len, len params, check byte.
// Outputs are strobes (no ready): cmd_valid, chk_err and frm_err are one-cycle, mutually exclusive.
module uart_cmd_resolver_p
  import uart_cmd_pkg::*;
#(
  parameter int         CLK_FREQ_HZ  = 50000000,
  parameter int         BAUD_RATE    = 115200,
  parameter int         MAX_PARA     = 4,
  parameter logic [7:0] HEADER_BYTE  = DEF_HEADER_BYTE,
  parameter int         CHK_MODE     = 0,
  parameter int         TIMEOUT_BITS = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  uart_rx,
  output logic                  cmd_valid,
  output logic [7:0]            cmd_code,
  output logic [7:0]            cmd_len,
  output logic [8*MAX_PARA-1:0] para_list,
  output logic [7:0]            check_rx,
  output logic                  chk_err,
  output logic                  frm_err,
  output logic                  busy
);

  localparam int   BIT_DIV  = CLK_FREQ_HZ / BAUD_RATE;
  localparam int   TO_LIMIT = TIMEOUT_BITS * BIT_DIV;
  localparam int   TW       = $clog2(TO_LIMIT + 1);
  localparam int   IW       = $clog2(MAX_PARA + 1);
  localparam int   PW       = 8 * MAX_PARA;
  localparam logic MODE     = (CHK_MODE != 0) ? CHK_XOR : CHK_SUM;

  logic       rx_vld, rx_ferr;
  logic [7:0] rx_data;

  uart_rx_core #(.CLK_FREQ_HZ(CLK_FREQ_HZ), .BAUD_RATE(BAUD_RATE)) u_rx (
    .clk(clk), .rst(rst), .uart_rx(uart_rx),
    .rx_vld(rx_vld), .rx_data(rx_data), .rx_ferr(rx_ferr)
  );

  state_e        state_q, state_d;
  logic [7:0]    acc_q, acc_d, code_q, code_d, len_q, len_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [PW-1:0] para_sh_q, para_sh_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          cmd_valid_q, cmd_valid_d, chk_err_q, chk_err_d, frm_err_q, frm_err_d;
  logic [7:0]    cmd_code_q, cmd_code_d, cmd_len_q, cmd_len_d, check_rx_q, check_rx_d;
  logic [PW-1:0] para_list_q, para_list_d;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    code_d      = code_q;
    len_d       = len_q;
    idx_d       = idx_q;
    para_sh_d   = para_sh_q;
    cmd_valid_d = 1'b0;
    chk_err_d   = 1'b0;
    frm_err_d   = 1'b0;
    cmd_code_d  = cmd_code_q;
    cmd_len_d   = cmd_len_q;
    para_list_d = para_list_q;
    check_rx_d  = check_rx_q;
    to_cnt_d    = (state_q == S_HDR || rx_vld) ? '0 : to_cnt_q + 1'b1;

    if (rx_vld) begin
      if (rx_ferr) begin
        // Framing errors only abort a frame in progress; noise while hunting is dropped.
        if (state_q != S_HDR) begin
          frm_err_d = 1'b1;
          state_d   = S_HDR;
        end
      end else begin
        case (state_q)
          S_HDR: if (rx_data == HEADER_BYTE) state_d = S_CMD;
          S_CMD: begin
            code_d  = rx_data;
            acc_d   = rx_data;
            state_d = S_LEN;
          end
          S_LEN: begin
            acc_d     = check_fold(MODE, acc_q, rx_data);
            len_d     = rx_data;
            para_sh_d = '0;
            idx_d     = '0;
            if (rx_data > 8'(MAX_PARA)) begin
              frm_err_d = 1'b1;
              state_d   = S_HDR;
            end else if (rx_data == 8'd0) begin
              state_d = S_CHK;
            end else begin
              state_d = S_PARA;
            end
          end
          S_PARA: begin
            acc_d = check_fold(MODE, acc_q, rx_data);
            for (int k = 0; k < MAX_PARA; k++) begin
              if (idx_q == IW'(k)) para_sh_d[k*8 +: 8] = rx_data;
            end
            idx_d = idx_q + 1'b1;
            if (8'(idx_q) + 8'd1 == len_q) state_d = S_CHK;
          end
          S_CHK: begin
            check_rx_d = rx_data;
            if (rx_data == acc_q) begin
              cmd_valid_d = 1'b1;
              cmd_code_d  = code_q;
              cmd_len_d   = len_q;
              para_list_d = para_sh_q;
            end else begin
              chk_err_d = 1'b1;
            end
            state_d = S_HDR;
          end
          default: state_d = S_HDR;
        endcase
      end
    end else if (state_q != S_HDR && to_cnt_q == TW'(TO_LIMIT)) begin
      frm_err_d = 1'b1;
      state_d   = S_HDR;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_HDR;
      acc_q       <= '0;
      code_q      <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      para_sh_q   <= '0;
      to_cnt_q    <= '0;
      cmd_valid_q <= 1'b0;
      chk_err_q   <= 1'b0;
      frm_err_q   <= 1'b0;
      cmd_code_q  <= '0;
      cmd_len_q   <= '0;
      para_list_q <= '0;
      check_rx_q  <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      code_q      <= code_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      para_sh_q   <= para_sh_d;
      to_cnt_q    <= to_cnt_d;
      cmd_valid_q <= cmd_valid_d;
      chk_err_q   <= chk_err_d;
      frm_err_q   <= frm_err_d;
      cmd_code_q  <= cmd_code_d;
      cmd_len_q   <= cmd_len_d;
      para_list_q <= para_list_d;
      check_rx_q  <= check_rx_d;
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign chk_err   = chk_err_q;
  assign frm_err   = frm_err_q;
  assign cmd_code  = cmd_code_q;
  assign cmd_len   = cmd_len_q;
  assign para_list = para_list_q;
  assign check_rx  = check_rx_q;
  assign busy      = (state_q != S_HDR);

endmodule

// File: tb/tb_uart_cmd_resolver_p.sv
// Bench for uart_cmd_resolver_p: a sum-mode and an XOR-mode instance driven
// with directed frames; a monitor checks every strobe against an expected queue.
module tb_uart_cmd_resolver_p;

  localparam int CLK_HZ  = 1000000;
  localparam int BAUD    = 100000;
  localparam int BIT_DIV = CLK_HZ / BAUD;
  localparam logic [1:0] K_VALID = 2'd0, K_CHK = 2'd1, K_FRM = 2'd2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx_s = 1'b1, rx_x = 1'b1;

  logic v_s, ce_s, fe_s, busy_s, v_x, ce_x, fe_x, busy_x;
  logic [7:0] code_s, len_s, chk_s, code_x, len_x, chk_x;
  logic [31:0] para_s, para_x;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  uart_cmd_resolver_p #(.CLK_FREQ_HZ(CLK_HZ), .BAUD_RATE(BAUD), .MAX_PARA(4),
    .HEADER_BYTE(8'hAA), .CHK_MODE(0), .TIMEOUT_BITS(32)) dut_s (
    .clk(clk), .rst(rst), .uart_rx(rx_s), .cmd_valid(v_s), .cmd_code(code_s),
    .cmd_len(len_s), .para_list(para_s), .check_rx(chk_s), .chk_err(ce_s),
    .frm_err(fe_s), .busy(busy_s));

  uart_cmd_resolver_p #(.CLK_FREQ_HZ(CLK_HZ), .BAUD_RATE(BAUD), .MAX_PARA(4),
    .HEADER_BYTE(8'hAA), .CHK_MODE(1), .TIMEOUT_BITS(32)) dut_x (
    .clk(clk), .rst(rst), .uart_rx(rx_x), .cmd_valid(v_x), .cmd_code(code_x),
    .cmd_len(len_x), .para_list(para_x), .check_rx(chk_x), .chk_err(ce_x),
    .frm_err(fe_x), .busy(busy_x));

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [57:0] exp_s_q[$];
  logic [57:0] exp_x_q[$];
  logic [7:0]  m_code[2], m_len[2], m_chk[2];
  logic [31:0] m_para[2];
  logic        prev_evt[2];
  logic [7:0]  frm_q[$];
  int          vld_cnt = 0;

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_code[i] = '0; m_len[i] = '0; m_chk[i] = '0; m_para[i] = '0; prev_evt[i] = 1'b0;
    end
  end

  always @(posedge clk) if (dut_s.u_rx.rx_vld) vld_cnt++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_evt(input int sel, input logic [1:0] kind, input logic [7:0] code,
                            input logic [7:0] len, input logic [31:0] para, input logic [7:0] chk);
    if (kind == K_VALID) begin
      m_code[sel] = code; m_len[sel] = len; m_para[sel] = para; m_chk[sel] = chk;
    end else if (kind == K_CHK) begin
      m_chk[sel] = chk;
    end
    if (sel == 0) exp_s_q.push_back({kind, m_code[0], m_len[0], m_para[0], m_chk[0]});
    else          exp_x_q.push_back({kind, m_code[1], m_len[1], m_para[1], m_chk[1]});
  endtask

  // ---------------- monitor ----------------
  task automatic mon(input int sel, input logic v, input logic ce, input logic fe,
                     input logic [55:0] outs);
    logic [1:0]  kind;
    logic [57:0] e;
    logic        have;
    int          n;
    n    = int'(v) + int'(ce) + int'(fe);
    have = 1'b0;
    e    = '0;
    if (n != 0) begin
      kind = (n > 1) ? 2'd3 : (v ? K_VALID : (ce ? K_CHK : K_FRM));
      check($sformatf("strobe_gap%0d", sel), 64'(prev_evt[sel]), 64'd0);
      if (sel == 0) begin
        if (exp_s_q.size() != 0) begin e = exp_s_q.pop_front(); have = 1'b1; end
      end else begin
        if (exp_x_q.size() != 0) begin e = exp_x_q.pop_front(); have = 1'b1; end
      end
      if (have) begin
        check($sformatf("event%0d", sel), 64'({kind, outs}), 64'(e));
      end else begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_event%0d: got %h expected none", sel, {kind, outs});
      end
    end
    prev_evt[sel] = (n != 0);
  endtask

  always @(negedge clk) mon(0, v_s, ce_s, fe_s, {code_s, len_s, para_s, chk_s});
  always @(negedge clk) mon(1, v_x, ce_x, fe_x, {code_x, len_x, para_x, chk_x});

  // ---------------- driver tasks ----------------
  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_line(input int sel, input logic b);
    if (sel == 0) rx_s = b;
    else          rx_x = b;
  endtask

  task automatic send_byte(input int sel, input logic [7:0] b, input logic stop_bit);
    set_line(sel, 1'b0);
    wait_clks(BIT_DIV);
    for (int i = 0; i < 8; i++) begin
      set_line(sel, b[i]);
      wait_clks(BIT_DIV);
    end
    set_line(sel, stop_bit);
    wait_clks(BIT_DIV);
    set_line(sel, 1'b1);
  endtask

  task automatic send_frame(input int sel);
    for (int i = 0; i < frm_q.size(); i++) send_byte(sel, frm_q[i], 1'b1);
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while ((exp_s_q.size() != 0 || exp_x_q.size() != 0) && t < 5000) begin
      wait_clks(1);
      t++;
    end
    check(name, 64'(exp_s_q.size() + exp_x_q.size()), 64'd0);
    wait_clks(3 * BIT_DIV);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int v0;
    wait_clks(5);
    check("reset_s", 64'({v_s, ce_s, fe_s, busy_s, code_s, len_s, para_s, chk_s}), 64'd0);
    check("reset_x", 64'({v_x, ce_x, fe_x, busy_x, code_x, len_x, para_x, chk_x}), 64'd0);
    rst = 1'b0;
    wait_clks(5);

    // 1: good sum-mode frame with MAX_PARA params
    expect_evt(0, K_VALID, 8'h01, 8'h04, 32'h44332211, 8'hAF);
    frm_q = {8'hAA, 8'h01, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAF};
    send_frame(0);
    drain("drain_t1");

    // 2: XOR mode good frame, then bad check keeps outputs
    expect_evt(1, K_VALID, 8'h01, 8'h04, 32'h44332211, 8'h41);
    frm_q = {8'hAA, 8'h01, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'h41};
    send_frame(1);
    drain("drain_t2a");
    expect_evt(1, K_CHK, 8'h00, 8'h00, 32'h0, 8'h42);
    frm_q = {8'hAA, 8'h01, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'h42};
    send_frame(1);
    drain("drain_t2b");
    check("hold_x", 64'({code_x, len_x, para_x, chk_x}), 64'({8'h01, 8'h04, 32'h44332211, 8'h42}));

    // 3: length over MAX_PARA (6 and the boundary 5), then zero-length frame
    expect_evt(0, K_FRM, 8'h00, 8'h00, 32'h0, 8'h00);
    frm_q = {8'hAA, 8'h05, 8'h06};
    send_frame(0);
    expect_evt(0, K_FRM, 8'h00, 8'h00, 32'h0, 8'h00);
    frm_q = {8'hAA, 8'h07, 8'h05};
    send_frame(0);
    expect_evt(0, K_VALID, 8'h02, 8'h00, 32'h0, 8'h02);
    frm_q = {8'hAA, 8'h02, 8'h00, 8'h02};
    send_frame(0);
    drain("drain_t3");

    // 4: garbage before header, back-to-back bytes
    expect_evt(0, K_VALID, 8'h03, 8'h01, 32'h0000007E, 8'h82);
    frm_q = {8'h55, 8'h13, 8'hAA, 8'h03, 8'h01, 8'h7E, 8'h82};
    send_frame(0);
    drain("drain_t4");

    // 5: inter-byte timeout, recovery, low stop bit on a param byte
    expect_evt(0, K_FRM, 8'h00, 8'h00, 32'h0, 8'h00);
    frm_q = {8'hAA, 8'h01, 8'h02, 8'h10};
    send_frame(0);
    check("busy_mid", 64'(busy_s), 64'd1);
    wait_clks(34 * BIT_DIV);
    drain("drain_t5a");
    check("busy_after_to", 64'(busy_s), 64'd0);
    expect_evt(0, K_VALID, 8'h05, 8'h01, 32'h00000009, 8'h0F);
    frm_q = {8'hAA, 8'h05, 8'h01, 8'h09, 8'h0F};
    send_frame(0);
    drain("drain_t5b");
    expect_evt(0, K_FRM, 8'h00, 8'h00, 32'h0, 8'h00);
    frm_q = {8'hAA, 8'h01, 8'h04, 8'h11};
    send_frame(0);
    send_byte(0, 8'h22, 1'b0);
    drain("drain_t5c");

    // 6: reset mid param byte, then a good frame, then an idle-line glitch
    frm_q = {8'hAA, 8'h01, 8'h04, 8'h11};
    send_frame(0);
    set_line(0, 1'b0);
    wait_clks(3 * BIT_DIV);
    rst = 1'b1;
    set_line(0, 1'b1);
    wait_clks(1);
    rst = 1'b0;
    m_code[0] = '0; m_len[0] = '0; m_para[0] = '0; m_chk[0] = '0;
    wait_clks(2 * BIT_DIV);
    check("rst_mid", 64'({v_s, ce_s, fe_s, busy_s, code_s, len_s, para_s, chk_s}), 64'd0);
    expect_evt(0, K_VALID, 8'h01, 8'h04, 32'h44332211, 8'hAF);
    frm_q = {8'hAA, 8'h01, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAF};
    send_frame(0);
    drain("drain_t6");
    v0 = vld_cnt;
    set_line(0, 1'b0);
    wait_clks(1);
    set_line(0, 1'b1);
    wait_clks(3 * BIT_DIV);
    check("glitch_rx_vld", 64'(vld_cnt - v0), 64'd0);
    check("glitch_busy", 64'(busy_s), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
